// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage next-PC generator.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      PCG_RUN       = 2'd0,
      PCG_JALR_WAIT = 2'd1,
      PCG_TRAP_WAIT = 2'd2
   } pcg_state_e;

   // Bit positions inside the mini decoder's JUMP_TYPE field
   localparam int JT_JAL  = 0;
   localparam int JT_BR   = 1;
   localparam int JT_JALR = 2;

   localparam int INSN_BYTES = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch PC bus: decoder/execute side is master, pc_gen is slave.
interface pc_gen_if #(
   parameter int XLEN = 64
);
   logic            pipeline_update;
   logic [2:0]      jump_type;
   logic [XLEN-1:0] imm_jump;
   logic            ex_redirect_valid;
   logic [XLEN-1:0] ex_redirect_pc;
   logic            jalr_resolve_valid;
   logic [XLEN-1:0] jalr_resolve_pc;
   logic [XLEN-1:0] pc;
   logic            fetch_valid;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            fetch_misaligned;

   modport master (
      output pipeline_update, jump_type, imm_jump,
             ex_redirect_valid, ex_redirect_pc,
             jalr_resolve_valid, jalr_resolve_pc,
      input  pc, fetch_valid, pred_taken, pred_target, fetch_misaligned
   );

   modport slave (
      input  pipeline_update, jump_type, imm_jump,
             ex_redirect_valid, ex_redirect_pc,
             jalr_resolve_valid, jalr_resolve_pc,
      output pc, fetch_valid, pred_taken, pred_target, fetch_misaligned
   );
endinterface

// File: rtl/pc_gen_target.sv
// Static next-PC predictor: JAL taken, branches via BTFN when PC_GEN_BTFN_EN
// is defined (otherwise not taken), JALR left to execute.
module pc_gen_target
   import pc_gen_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic [2:0]      jump_type_i,
   input  logic [XLEN-1:0] imm_jump_i,
   output logic            taken_o,
   output logic [XLEN-1:0] target_o
);

   logic br_taken_pred;

`ifdef PC_GEN_BTFN_EN
   // Negative offset means a backward branch, typically a loop back-edge
   assign br_taken_pred = imm_jump_i[XLEN-1];
`else
   assign br_taken_pred = 1'b0;
`endif

   assign taken_o  = jump_type_i[JT_JAL] | (jump_type_i[JT_BR] & br_taken_pred);
   assign target_o = taken_o ? (pc_i + imm_jump_i) : (pc_i + XLEN'(INSN_BYTES));

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register and RUN/JALR_WAIT/TRAP_WAIT control for the RV64I core.
// Branch prediction policy selected by PC_GEN_BTFN_EN (see pc_gen_target).
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          XLEN     = 64
) (
   input  logic   clk,
   input  logic   rst,
   pc_gen_if.slave bus
);

   pcg_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            fv_q, fv_d;
   logic            mis_q, mis_d;
   logic            taken;
   logic [XLEN-1:0] target;
   logic            load;

   pc_gen_target #(.XLEN(XLEN)) u_target (
      .pc_i        (pc_q),
      .jump_type_i (bus.jump_type),
      .imm_jump_i  (bus.imm_jump),
      .taken_o     (taken),
      .target_o    (target)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fv_d    = 1'b0;
      mis_d   = 1'b0;
      load    = 1'b0;
      if (bus.ex_redirect_valid) begin
         pc_d    = bus.ex_redirect_pc;
         state_d = PCG_RUN;
         load    = 1'b1;
      end else begin
         case (state_q)
            PCG_RUN: begin
               if (bus.pipeline_update && bus.jump_type[JT_JALR]) begin
                  state_d = PCG_JALR_WAIT;
               end else if (bus.pipeline_update) begin
                  pc_d = target;
                  load = 1'b1;
                  fv_d = 1'b1;
               end else begin
                  fv_d = 1'b1;
               end
            end
            PCG_JALR_WAIT: begin
               if (bus.jalr_resolve_valid) begin
                  pc_d    = bus.jalr_resolve_pc;
                  state_d = PCG_RUN;
                  load    = 1'b1;
                  fv_d    = 1'b1;
               end
            end
            default: ;
         endcase
      end
      // A misaligned target is presented once so decode can raise the trap
      if (load && pc_d[1]) begin
         state_d = PCG_TRAP_WAIT;
         fv_d    = 1'b1;
         mis_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PCG_RUN;
         pc_q    <= RESET_PC;
         fv_q    <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fv_q    <= fv_d;
         mis_q   <= mis_d;
      end
   end

   assign bus.pc               = pc_q;
   assign bus.fetch_valid      = fv_q;
   assign bus.fetch_misaligned = mis_q;
   assign bus.pred_taken       = taken;
   assign bus.pred_target      = target;

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen with RESET_PC=0x1000.
module tb_pc_gen;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   pc_gen_if #(.XLEN(64)) bus ();

   pc_gen #(.RESET_PC(64'h1000), .XLEN(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [63:0] tgt);
      bus.ex_redirect_valid = 1'b1;
      bus.ex_redirect_pc    = tgt;
      tick();
      bus.ex_redirect_valid = 1'b0;
   endtask

`ifdef PC_GEN_BTFN_EN
   localparam logic [63:0] BR_PC    = 64'h2FF0;
   localparam logic        BR_TAKEN = 1'b1;
`else
   localparam logic [63:0] BR_PC    = 64'h3004;
   localparam logic        BR_TAKEN = 1'b0;
`endif

   initial begin
      rst                    = 1'b1;
      bus.pipeline_update    = 1'b1;
      bus.jump_type          = 3'b000;
      bus.imm_jump           = '0;
      bus.ex_redirect_valid  = 1'b0;
      bus.ex_redirect_pc     = '0;
      bus.jalr_resolve_valid = 1'b0;
      bus.jalr_resolve_pc    = '0;
      tick();
      tick();
      chk("rst_pc", bus.pc, 64'h1000);
      chk("rst_fv", 64'(bus.fetch_valid), 64'd0);
      chk("rst_tgt", bus.pred_target, 64'h1004);
      chk("rst_taken", 64'(bus.pred_taken), 64'd0);
      chk("rst_mis", 64'(bus.fetch_misaligned), 64'd0);

      rst = 1'b0;
      tick();
      chk("seq_pc1", bus.pc, 64'h1004);
      chk("seq_fv1", 64'(bus.fetch_valid), 64'd1);
      tick();
      chk("seq_pc2", bus.pc, 64'h1008);

      // JAL forward and backward
      redirect(64'h2000);
      chk("redir_pc", bus.pc, 64'h2000);
      chk("redir_fv", 64'(bus.fetch_valid), 64'd0);
      bus.jump_type = 3'b001;
      bus.imm_jump  = 64'h100;
      #1;
      chk("jal_taken", 64'(bus.pred_taken), 64'd1);
      chk("jal_tgt", bus.pred_target, 64'h2100);
      tick();
      chk("jal_pc", bus.pc, 64'h2100);
      chk("jal_fv", 64'(bus.fetch_valid), 64'd1);
      bus.jump_type = 3'b000;
      redirect(64'h2000);
      bus.jump_type = 3'b001;
      bus.imm_jump  = 64'hFFFF_FFFF_FFFF_FFF8;
      tick();
      chk("jal_back_pc", bus.pc, 64'h1FF8);

      // Backward branch
      bus.jump_type = 3'b000;
      redirect(64'h3000);
      bus.jump_type = 3'b010;
      bus.imm_jump  = 64'hFFFF_FFFF_FFFF_FFF0;
      #1;
      chk("br_taken", 64'(bus.pred_taken), 64'(BR_TAKEN));
      tick();
      chk("br_pc", bus.pc, BR_PC);

      // Stall holds pc
      bus.jump_type       = 3'b000;
      bus.pipeline_update = 1'b0;
      tick();
      chk("stall_pc", bus.pc, BR_PC);
      chk("stall_fv", 64'(bus.fetch_valid), 64'd1);
      bus.pipeline_update = 1'b1;

      // JALR wait then resolve
      redirect(64'h4000);
      bus.jump_type = 3'b100;
      tick();
      bus.jump_type = 3'b000;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("jalr_hold_pc%0d", i), bus.pc, 64'h4000);
         chk($sformatf("jalr_hold_fv%0d", i), 64'(bus.fetch_valid), 64'd0);
         if (i < 4) tick();
      end
      bus.jalr_resolve_valid = 1'b1;
      bus.jalr_resolve_pc    = 64'h8000;
      tick();
      bus.jalr_resolve_valid = 1'b0;
      chk("jalr_res_pc", bus.pc, 64'h8000);
      chk("jalr_res_fv", 64'(bus.fetch_valid), 64'd1);

      // Redirect beats resolve
      bus.jump_type = 3'b100;
      tick();
      bus.jump_type          = 3'b000;
      bus.jalr_resolve_valid = 1'b1;
      bus.jalr_resolve_pc    = 64'h8000;
      bus.ex_redirect_valid  = 1'b1;
      bus.ex_redirect_pc     = 64'h9000;
      tick();
      bus.jalr_resolve_valid = 1'b0;
      bus.ex_redirect_valid  = 1'b0;
      chk("both_pc", bus.pc, 64'h9000);
      tick();
      chk("both_run_pc", bus.pc, 64'h9004);
      chk("both_run_fv", 64'(bus.fetch_valid), 64'd1);

      // Misaligned redirect and trap recovery
      redirect(64'h5002);
      chk("mis_flag", 64'(bus.fetch_misaligned), 64'd1);
      chk("mis_fv", 64'(bus.fetch_valid), 64'd1);
      bus.jump_type = 3'b001;
      bus.imm_jump  = 64'h100;
      tick();
      chk("trap_mis", 64'(bus.fetch_misaligned), 64'd0);
      chk("trap_fv", 64'(bus.fetch_valid), 64'd0);
      tick();
      chk("trap_pc", bus.pc, 64'h5002);
      chk("trap_fv2", 64'(bus.fetch_valid), 64'd0);
      bus.jump_type = 3'b000;
      redirect(64'h100);
      chk("vec_pc", bus.pc, 64'h100);
      tick();
      chk("vec_run_pc", bus.pc, 64'h104);
      chk("vec_run_fv", 64'(bus.fetch_valid), 64'd1);

      // Address wrap
      redirect(64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_tgt", bus.pred_target, 64'h0);
      tick();
      chk("wrap_pc", bus.pc, 64'h0);

      // Reset while waiting on JALR drops the pending resolve
      bus.jump_type = 3'b100;
      tick();
      bus.jump_type          = 3'b000;
      rst                    = 1'b1;
      bus.jalr_resolve_valid = 1'b1;
      bus.jalr_resolve_pc    = 64'h8000;
      tick();
      rst                    = 1'b0;
      bus.jalr_resolve_valid = 1'b0;
      chk("rst2_pc", bus.pc, 64'h1000);
      chk("rst2_fv", 64'(bus.fetch_valid), 64'd0);
      tick();
      chk("rst2_run_pc", bus.pc, 64'h1004);
      chk("rst2_run_fv", 64'(bus.fetch_valid), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
